hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage PCPU. It drives the stall/flush controls that the pipeline registers consume: PC_Write, IF_ID_Write/Flush, ID_EX_Write/Flush and EX_MEM_Flush. It resolves load-use hazards, taken-branch flushes, multi-cycle MDU (mult/div) occupancy of EX, and memory wait. It also keeps saturating stall and flush statistics.

---
 rtl/pcpu_pkg.sv | 25 ++
 rtl/hazard_ctrl_if.sv | 49 ++++
 rtl/sat_counter.sv | 29 ++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcpu_pkg
// Description : Shared types and constants for the 5-stage PCPU hazard logic.
//               Holds the hazard controller state encoding, the hard-wired
//               zero register index and the default MDU occupancy.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pcpu_pkg;

   // Hazard controller FSM states.
   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MDU_BUSY = 1'b1
   } hz_state_t;

   // $zero never carries a real dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Default number of cycles a mult/div occupies EX.
   localparam int MDU_LAT_DEF = 4;

endpackage : pcpu_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle between the pipeline datapath and the hazard
//               controller. The datapath (master) reports hazard sources and
//               consumes the stall/flush controls; the controller (slave)
//               does the reverse.
// Signals     : mem_wait, ID_EX_MemRead, ID_EX_rt, IF_ID_rs, IF_ID_rt,
//               IF_ID_uses_rt, branch_taken, mdu_start      (datapath -> ctrl)
//               PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
//               ID_EX_Flush, EX_MEM_Flush                   (ctrl -> datapath)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;

   // Hazard sources
   logic       mem_wait;
   logic       ID_EX_MemRead;
   logic [4:0] ID_EX_rt;
   logic [4:0] IF_ID_rs;
   logic [4:0] IF_ID_rt;
   logic       IF_ID_uses_rt;
   logic       branch_taken;
   logic       mdu_start;

   // Pipeline register controls
   logic       PC_Write;
   logic       IF_ID_Write;
   logic       IF_ID_Flush;
   logic       ID_EX_Write;
   logic       ID_EX_Flush;
   logic       EX_MEM_Flush;

   modport master (
      output mem_wait, ID_EX_MemRead, ID_EX_rt, IF_ID_rs, IF_ID_rt,
             IF_ID_uses_rt, branch_taken, mdu_start,
      input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
             ID_EX_Flush, EX_MEM_Flush
   );

   modport slave (
      input  mem_wait, ID_EX_MemRead, ID_EX_rt, IF_ID_rs, IF_ID_rt,
             IF_ID_uses_rt, branch_taken, mdu_start,
      output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
             ID_EX_Flush, EX_MEM_Flush
   );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset, clears the count
//               inc   - count this cycle
//               count - current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             inc,
   output logic [CNT_W-1:0]      count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush controller for the 5-stage PCPU. Resolves memory
//               wait, taken branches, multi-cycle MDU occupancy of EX and
//               load-use hazards, and keeps saturating stall/flush counts.
//               Controls are Mealy outputs so a hazard is acted on in the
//               cycle it is seen.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous active-low reset
//               hz           - hazard sources in, pipeline controls out
//               mdu_busy     - FSM is in MDU_BUSY
//               stall_cycles - cycles with PC_Write==0, saturating
//               flush_events - taken-branch flushes, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import pcpu_pkg::*;
#(
   parameter int MDU_LAT = MDU_LAT_DEF,
   parameter int CNT_W   = 32
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   hazard_ctrl_if.slave      hz,
   output logic              mdu_busy,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_events
);

   localparam int CW = $clog2(MDU_LAT);
   // Loaded on MDU entry; the cycle with cnt==1 is the release cycle, so the
   // instruction spends MDU_LAT-1 frozen cycles plus one advancing cycle.
   localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   hz_state_t      r_state;
   logic [CW-1:0]  r_cnt;

   hz_state_t      w_next_state;
   logic [CW-1:0]  w_next_cnt;
   logic           w_pc_write;
   logic           w_if_id_write;
   logic           w_if_id_flush;
   logic           w_id_ex_write;
   logic           w_id_ex_flush;
   logic           w_ex_mem_flush;
   logic           w_flush_inc;
   logic           w_load_use;

   assign w_load_use = hz.ID_EX_MemRead && (hz.ID_EX_rt != REG_ZERO) &&
                       ((hz.ID_EX_rt == hz.IF_ID_rs) ||
                        (hz.IF_ID_uses_rt && (hz.ID_EX_rt == hz.IF_ID_rt)));

   always_comb begin
      w_next_state   = r_state;
      w_next_cnt     = r_cnt;
      w_pc_write     = 1'b1;
      w_if_id_write  = 1'b1;
      w_if_id_flush  = 1'b0;
      w_id_ex_write  = 1'b1;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_flush = 1'b0;
      w_flush_inc    = 1'b0;

      if (!rst_n) begin
         // Hold PC and fill every stage with bubbles.
         w_pc_write     = 1'b0;
         w_if_id_flush  = 1'b1;
         w_id_ex_flush  = 1'b1;
         w_ex_mem_flush = 1'b1;
      end else if (hz.mem_wait) begin
         w_pc_write    = 1'b0;
         w_if_id_write = 1'b0;
         w_id_ex_write = 1'b0;
      end else if ((r_state == ST_RUN) && hz.branch_taken) begin
         // Branch wins over a same-cycle mdu_start or load-use.
         w_if_id_flush = 1'b1;
         w_id_ex_flush = 1'b1;
         w_flush_inc   = 1'b1;
      end else if ((r_state == ST_RUN) && hz.mdu_start) begin
         w_pc_write     = 1'b0;
         w_if_id_write  = 1'b0;
         w_id_ex_write  = 1'b0;
         w_ex_mem_flush = 1'b1;
         w_next_state   = ST_MDU_BUSY;
         w_next_cnt     = CNT_INIT;
      end else if ((r_state == ST_MDU_BUSY) && (r_cnt > CNT_ONE)) begin
         w_pc_write     = 1'b0;
         w_if_id_write  = 1'b0;
         w_id_ex_write  = 1'b0;
         w_ex_mem_flush = 1'b1;
         w_next_cnt     = r_cnt - CNT_ONE;
      end else begin
         // RUN or the MDU release cycle: the load-use check applies here.
         if (r_state == ST_MDU_BUSY) begin
            w_next_state = ST_RUN;
            w_next_cnt   = '0;
         end
         if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   assign hz.PC_Write     = w_pc_write;
   assign hz.IF_ID_Write  = w_if_id_write;
   assign hz.IF_ID_Flush  = w_if_id_flush;
   assign hz.ID_EX_Write  = w_id_ex_write;
   assign hz.ID_EX_Flush  = w_id_ex_flush;
   assign hz.EX_MEM_Flush = w_ex_mem_flush;
   assign mdu_busy        = (r_state == ST_MDU_BUSY);

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (!w_pc_write),
      .count (stall_cycles)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_flush_inc),
      .count (flush_events)
   );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (MDU_LAT=4,
//               narrow 4-bit statistics so saturation is reachable).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int TB_CNT_W = 4;
   localparam logic [TB_CNT_W-1:0] SAT = '1;

   // Expected control pattern order:
   // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush}
   localparam logic [5:0] C_DEF   = 6'b110100;
   localparam logic [5:0] C_LU    = 6'b000110;
   localparam logic [5:0] C_BR    = 6'b111110;
   localparam logic [5:0] C_MW    = 6'b000000;
   localparam logic [5:0] C_MDU   = 6'b000001;
   localparam logic [5:0] C_RESET = 6'b011111;

   typedef struct {
      logic       mw;
      logic       mr;
      logic [4:0] ert;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urt;
      logic       br;
      logic       ms;
      logic [5:0] ctl;
      logic       busy;
      logic       finc;
   } vec_t;

   logic                 clk;
   logic                 rst_n;
   logic                 mdu_busy;
   logic [TB_CNT_W-1:0]  stall_cycles;
   logic [TB_CNT_W-1:0]  flush_events;

   int n_vec;
   int n_err;
   logic [TB_CNT_W-1:0] exp_stall;
   logic [TB_CNT_W-1:0] exp_flush;

   hazard_ctrl_if hz_if ();

   hazard_ctrl #(
      .MDU_LAT (4),
      .CNT_W   (TB_CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hz           (hz_if.slave),
      .mdu_busy     (mdu_busy),
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic mw, input logic mr,
                               input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt,
                               input logic br, input logic ms,
                               input logic [5:0] ctl, input logic busy,
                               input logic finc);
      vec_t v;
      v.mw = mw; v.mr = mr; v.ert = ert; v.rs = rs; v.rt = rt; v.urt = urt;
      v.br = br; v.ms = ms; v.ctl = ctl; v.busy = busy; v.finc = finc;
      return v;
   endfunction

   function automatic logic [5:0] ctl_now();
      return {hz_if.PC_Write, hz_if.IF_ID_Write, hz_if.IF_ID_Flush,
              hz_if.ID_EX_Write, hz_if.ID_EX_Flush, hz_if.EX_MEM_Flush};
   endfunction

   task automatic chk_ctl(input string name, input logic [5:0] ctl,
                          input logic busy);
      n_vec++;
      if ((ctl_now() !== ctl) || (mdu_busy !== busy)) begin
         n_err++;
         $display("FAIL %s: ctl/busy got %b/%b expected %b/%b",
                  name, ctl_now(), mdu_busy, ctl, busy);
      end
   endtask

   task automatic chk_stats(input string name);
      n_vec++;
      if ((stall_cycles !== exp_stall) || (flush_events !== exp_flush)) begin
         n_err++;
         $display("FAIL %s: stall/flush got %0d/%0d expected %0d/%0d",
                  name, stall_cycles, flush_events, exp_stall, exp_flush);
      end
   endtask

   task automatic drive(input vec_t v);
      hz_if.mem_wait      = v.mw;
      hz_if.ID_EX_MemRead = v.mr;
      hz_if.ID_EX_rt      = v.ert;
      hz_if.IF_ID_rs      = v.rs;
      hz_if.IF_ID_rt      = v.rt;
      hz_if.IF_ID_uses_rt = v.urt;
      hz_if.branch_taken  = v.br;
      hz_if.mdu_start     = v.ms;
   endtask

   // One cycle: drive at negedge, check controls mid-cycle, check stats
   // after the following rising edge.
   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      drive(v);
      #1;
      chk_ctl(name, v.ctl, v.busy);
      @(posedge clk);
      #1;
      if (!v.ctl[5] && (exp_stall != SAT)) exp_stall++;
      if (v.finc && (exp_flush != SAT)) exp_flush++;
      chk_stats(name);
   endtask

   vec_t tbl[17];
   vec_t idle;

   initial begin
      n_vec = 0;
      n_err = 0;
      exp_stall = '0;
      exp_flush = '0;
      idle = mk(0,0,5'd0,5'd0,5'd0,0,0,0, C_DEF,0,0);

      //           mw mr ert    rs     rt    urt br ms ctl    busy finc
      tbl[0]  = mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 0);
      tbl[1]  = mk(0, 1, 5'd5,  5'd5,  5'd0,  0, 0, 0, C_LU,  0, 0);
      tbl[2]  = mk(0, 1, 5'd7,  5'd3,  5'd7,  1, 0, 0, C_LU,  0, 0);
      tbl[3]  = mk(0, 1, 5'd7,  5'd3,  5'd7,  0, 0, 0, C_DEF, 0, 0);
      tbl[4]  = mk(0, 1, 5'd0,  5'd0,  5'd0,  1, 0, 0, C_DEF, 0, 0);
      tbl[5]  = mk(0, 0, 5'd5,  5'd5,  5'd5,  1, 0, 0, C_DEF, 0, 0);
      tbl[6]  = mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_BR,  0, 1);
      tbl[7]  = mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 1, C_BR,  0, 1);
      tbl[8]  = mk(0, 1, 5'd9,  5'd9,  5'd0,  0, 1, 0, C_BR,  0, 1);
      tbl[9]  = mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 0);
      tbl[10] = mk(1, 1, 5'd5,  5'd5,  5'd0,  0, 0, 0, C_MW,  0, 0);
      tbl[11] = mk(1, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, C_MW,  0, 0);
      tbl[12] = mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, C_MDU, 0, 0);
      tbl[13] = mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, C_MDU, 1, 0);
      tbl[14] = mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, C_MDU, 1, 0);
      tbl[15] = mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, C_DEF, 1, 0);
      tbl[16] = mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, C_DEF, 0, 0);

      // Reset held for three cycles
      rst_n = 1'b0;
      drive(idle);
      repeat (3) @(posedge clk);
      #1;
      chk_ctl("reset_ctl", C_RESET, 1'b0);
      chk_stats("reset_stats");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_ctl("after_reset", C_DEF, 1'b0);

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i], $sformatf("tbl[%0d]", i));
      end

      // MDU with two mem_wait cycles mid-busy, ignored branch, load-use on
      // the release cycle: EX occupancy stretches to six cycles.
      apply(mk(0,0,5'd0,5'd0,5'd0,0,0,1, C_MDU,0,0), "mw_mdu_start");
      apply(mk(0,0,5'd0,5'd0,5'd0,0,0,0, C_MDU,1,0), "mw_mdu_cnt3");
      apply(mk(1,0,5'd0,5'd0,5'd0,0,0,0, C_MW, 1,0), "mw_wait1");
      apply(mk(1,0,5'd0,5'd0,5'd0,0,0,0, C_MW, 1,0), "mw_wait2");
      apply(mk(0,0,5'd0,5'd0,5'd0,0,1,0, C_MDU,1,0), "mw_mdu_cnt2_br");
      apply(mk(0,1,5'd4,5'd1,5'd4,1,0,0, C_LU, 1,0), "mw_release_lu");
      apply(idle, "mw_run");

      // Drive the stall counter into saturation
      for (int i = 0; i < 4; i++) begin
         apply(mk(1,0,5'd0,5'd0,5'd0,0,0,0, C_MW,0,0), $sformatf("sat[%0d]", i));
      end
      n_vec++;
      if (stall_cycles !== SAT) begin
         n_err++;
         $display("FAIL stall_saturated: got %0d expected %0d", stall_cycles, SAT);
      end

      // Asynchronous reset while cnt==2 in MDU_BUSY
      apply(mk(0,0,5'd0,5'd0,5'd0,0,0,1, C_MDU,0,0), "rst_mdu_start");
      apply(mk(0,0,5'd0,5'd0,5'd0,0,0,0, C_MDU,1,0), "rst_mdu_cnt3");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_stall = '0;
      exp_flush = '0;
      chk_ctl("rst_mid_mdu_ctl", C_RESET, 1'b0);
      chk_stats("rst_mid_mdu_stats");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      apply(idle, "post_rst_idle0");
      apply(idle, "post_rst_idle1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_hazard_ctrl
`default_nettype wire
